// File: rtl/pwm_sched_pkg.sv
// Shared constants, duty type and index helper for the PWM duty scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pwm_sched_pkg;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DUTY_W   = 4;
    localparam int PERIOD       = 2 ** DEF_DUTY_W;

    typedef logic [DEF_DUTY_W-1:0] duty_t;

    // Circular successor of idx within 0..n-1.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pwm_rr_arbiter.sv
// Round-robin grant of one requester per cycle, searching circularly from pointer rr.
// Latency: grant is combinational; rr advances on the edge that completes a transfer.
// Backpressure: grant doubles as ready, so at most one requester is accepted per cycle.
module pwm_rr_arbiter
    import pwm_sched_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req_valid,
    output logic [CHANNELS-1:0] grant
);

    localparam int RR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [RR_W-1:0] rr;
    logic [RR_W-1:0] cand;
    logic [RR_W-1:0] gidx;
    logic            found;

    // Pick the first valid channel at or after rr; nothing is granted while in reset.
    always_comb begin
        grant = '0;
        cand  = '0;
        gidx  = rr;
        found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = RR_W'((int'(rr) + k) % CHANNELS);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        if (rst) begin
            found = 1'b0;
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    // Move the pointer past the channel that just transferred; hold it otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
        end else if (found) begin
            rr <= RR_W'(next_idx(int'(gidx), CHANNELS));
        end
    end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// Multi-channel PWM: arbitrated duty requests are shadowed and committed at the shared period boundary.
// Latency: a new duty appears on pwm one cycle after the first boundary edge following its transfer.
// Backpressure: one-hot req_ready per cycle; unserved requesters simply wait, nothing is dropped.
// Build option PWM_SLEW_LIMIT_EN: each boundary moves active duty one LSB toward the shadow value.
module pwm_duty_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DUTY_W   = DEF_DUTY_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        req_valid,
    input  logic [CHANNELS*DUTY_W-1:0] req_duty,
    output logic [CHANNELS-1:0]        req_ready,
    output logic [CHANNELS-1:0]        pwm,
    output logic                       period_start
);

    logic [DUTY_W-1:0]   cnt;
    logic                boundary;
    logic [CHANNELS-1:0] xfer;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] settled;
    logic [DUTY_W-1:0]   shadow     [CHANNELS];
    logic [DUTY_W-1:0]   active     [CHANNELS];
    logic [DUTY_W-1:0]   active_nxt [CHANNELS];

    pwm_rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .grant     (req_ready)
    );

    // The last counter value of a period is where pending duties are committed.
    assign boundary = (cnt == '1);
    assign xfer     = req_valid & req_ready;

    // Value each pending channel would take at the boundary, and whether that finishes it.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            active_nxt[i] = active[i];
            settled[i]    = 1'b1;
`ifdef PWM_SLEW_LIMIT_EN
            if (active[i] < shadow[i]) begin
                active_nxt[i] = active[i] + DUTY_W'(1);
            end else if (active[i] > shadow[i]) begin
                active_nxt[i] = active[i] - DUTY_W'(1);
            end
            settled[i] = (active_nxt[i] == shadow[i]);
`else
            active_nxt[i] = shadow[i];
`endif
        end
    end

    // Free-running period counter plus shadow/active/pending bookkeeping.
    // A transfer in the boundary cycle re-arms pending after the old shadow commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            pending <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            cnt <= cnt + DUTY_W'(1);
            for (int i = 0; i < CHANNELS; i++) begin
                if (boundary && pending[i]) begin
                    active[i] <= active_nxt[i];
                    if (settled[i]) begin
                        pending[i] <= 1'b0;
                    end
                end
                if (xfer[i]) begin
                    shadow[i]  <= req_duty[i*DUTY_W +: DUTY_W];
                    pending[i] <= 1'b1;
                end
            end
        end
    end

    // Registered compare outputs and the period marker, both aligned to cnt of the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm          <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= (cnt == '0);
            for (int i = 0; i < CHANNELS; i++) begin
                pwm[i] <= (cnt < active[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Directed bench for pwm_duty_scheduler: reset, round-robin, commit alignment, collisions, extremes.
// Tracks the period counter itself and predicts every observed value from hand-computed constants.
// With PWM_SLEW_LIMIT_EN defined the duty-step section swaps in the slew-limited expectations.
module tb_pwm_duty_scheduler;
    import pwm_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'b0;
    logic [15:0] req_duty = 16'h0;
    logic [3:0]  req_ready;
    logic [3:0]  pwm;
    logic        period_start;

    int passed = 0;
    int total  = 0;
    int ecnt   = 0;
    int hi [4];

    always #5 clk = ~clk;

    pwm_duty_scheduler #(
        .CHANNELS (4),
        .DUTY_W   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_duty     (req_duty),
        .req_ready    (req_ready),
        .pwm          (pwm),
        .period_start (period_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock: advance the bench's copy of cnt, then settle just past the edge.
    task automatic tick();
        @(posedge clk);
        ecnt = rst ? 0 : (ecnt + 1) % PERIOD;
        #1;
    endtask

    task automatic run_to(input int c);
        for (int n = 0; n < 2 * PERIOD && ecnt != c; n++) tick();
    endtask

    // Single-cycle request on one channel; the grant must go to it.
    task automatic xfer(input int ch, input int d, input string tag);
        req_duty[ch*4 +: 4] = 4'(d);
        req_valid = 4'(1 << ch);
        #1;
        chk(tag, 32'(req_ready), 32'(1 << ch));
        tick();
        req_valid = 4'b0;
    endtask

    // Count high cycles per channel over one full period starting at the period_start cycle.
    task automatic measure();
        run_to(1);
        chk("period_start_at_cnt1", 32'(period_start), 32'd1);
        for (int ch = 0; ch < 4; ch++) hi[ch] = 0;
        for (int n = 0; n < PERIOD; n++) begin
            for (int ch = 0; ch < 4; ch++) hi[ch] += int'(pwm[ch]);
            tick();
        end
    endtask

    initial begin
        int h;
        // Reset held three cycles with every requester asserting valid.
        req_valid = 4'b1111;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("reset_pwm", 32'(pwm), 32'd0);
            chk("reset_period_start", 32'(period_start), 32'd0);
            chk("reset_ready", 32'(req_ready), 32'd0);
        end
        rst = 1'b0;
        #1;

        // Round-robin: grants rotate 0,1,2,3,0,1,2,3; first period_start at cnt=1.
        for (int k = 0; k < 8; k++) begin
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            chk("rr_period_start", 32'(period_start), (k == 1) ? 32'd1 : 32'd0);
            chk("rr_pwm_low", 32'(pwm), 32'd0);
            tick();
        end
        req_valid = 4'b0;
        #1;
        chk("idle_ready", 32'(req_ready), 32'd0);

`ifdef PWM_SLEW_LIMIT_EN
        // Slew-limited 0 -> 3 on channel 0: 1, 2, 3 high cycles, then steady at 3.
        run_to(3);
        xfer(0, 3, "slew_ready0");
        for (int p = 0; p < 4; p++) begin
            measure();
            chk("slew_step", 32'(hi[0]), 32'((p < 3) ? p + 1 : 3));
        end
`else
        // Commit alignment: duty 5 on channel 2 requested at cnt=3.
        run_to(3);
        xfer(2, 5, "commit_ready2");
        h = 0;
        for (int n = 0; n < PERIOD && ecnt != 1; n++) begin
            h += int'(pwm[2]);
            tick();
        end
        chk("old_duty_hold", 32'(h), 32'd0);
        chk("commit_first_cycle", 32'(pwm[2]), 32'd1);
        measure();
        chk("commit_duty5_p1", 32'(hi[2]), 32'd5);
        measure();
        chk("commit_duty5_p2", 32'(hi[2]), 32'd5);

        // Boundary collision: pending 4 on channel 1, then 9 transferred at cnt=15.
        run_to(5);
        xfer(1, 4, "collide_ready_a");
        run_to(15);
        xfer(1, 9, "collide_ready_b");
        measure();
        chk("collide_old_commits", 32'(hi[1]), 32'd4);
        chk("collide_other_chan", 32'(hi[2]), 32'd5);
        measure();
        chk("collide_new_commits", 32'(hi[1]), 32'd9);

        // Extremes: duty 15 on channel 3, duty 0 on channel 0, across three periods.
        run_to(2);
        xfer(3, 15, "extreme_ready3");
        xfer(0, 0, "extreme_ready0");
        for (int p = 0; p < 3; p++) begin
            measure();
            chk("extreme_duty15", 32'(hi[3]), 32'd15);
            chk("extreme_duty0", 32'(hi[0]), 32'd0);
            chk("extreme_keep9", 32'(hi[1]), 32'd9);
        end
`endif

        // Reset mid-period with a request still pending: everything clears.
        run_to(4);
        xfer(0, 7, "midreset_ready0");
        run_to(6);
        rst = 1'b1;
        tick();
        chk("midreset_pwm", 32'(pwm), 32'd0);
        chk("midreset_period_start", 32'(period_start), 32'd0);
        rst = 1'b0;
        #1;
        measure();
        for (int ch = 0; ch < 4; ch++) begin
            chk("midreset_cleared", 32'(hi[ch]), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
